// File: rtl/mips_arb_pkg.sv
// Shared types for the unified instruction/data memory arbiter.
package mips_arb_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_e;

   typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} arb_owner_e;

   // Holds LAT-1 for the supported latency range 1..7.
   localparam int CNT_W = 3;

endpackage

// File: rtl/arb_perf_cnt.sv
// Bank of saturating event counters for arbiter stall/flush statistics.
module arb_perf_cnt #(
   parameter int N = 3,
   parameter int W = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [N-1:0]        inc,
   output logic [N-1:0][W-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (inc[i] && (cnt[i] != {W{1'b1}})) cnt[i] <= cnt[i] + 1'b1;
         end
      end
   end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates the IF fetch port and MEM load/store port onto one single-ported memory.
// Define ARB_PERF_CNT_EN to add the perf_if_stall/perf_d_stall/perf_flushed counters.
module unified_mem_arbiter
   import mips_arb_pkg::*;
#(
   parameter int LAT = 2,
   parameter int DW  = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          if_req,
   input  logic [DW-1:0] if_addr,
   input  logic          if_flush,
   output logic          if_ready,
   output logic [DW-1:0] if_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [DW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_ready,
   output logic [DW-1:0] d_rdata,
`ifdef ARB_PERF_CNT_EN
   output logic [31:0]   perf_if_stall,
   output logic [31:0]   perf_d_stall,
   output logic [31:0]   perf_flushed,
`endif
   output logic          mem_en,
   output logic          mem_we,
   output logic [DW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   arb_state_e       state, state_nxt;
   arb_owner_e       own;
   logic             we_q;
   logic [CNT_W-1:0] cnt;
   logic             cancel;
   logic             gnt_d, gnt_i, resp_last, drop_i, cancel_set;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (gnt_d || gnt_i) state_nxt = ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (cnt == '0) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Data port wins ties: the MEM-stage instruction is older than the fetch.
   always_comb begin
      gnt_d      = (state == IDLE) && d_req;
      gnt_i      = (state == IDLE) && !d_req && if_req && !if_flush;
      resp_last  = (state == WAIT) && (cnt == '0);
      cancel_set = if_flush && (own == OWN_I) && (state != IDLE);
      drop_i     = (cancel || if_flush) && (own == OWN_I);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         own       <= OWN_I;
         we_q      <= 1'b0;
         cnt       <= '0;
         cancel    <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_ready  <= 1'b0;
         d_ready   <= 1'b0;
         if_rdata  <= '0;
         d_rdata   <= '0;
      end else begin
         mem_en   <= gnt_d || gnt_i;
         mem_we   <= gnt_d && d_we;
         if_ready <= resp_last && (own == OWN_I) && !drop_i;
         d_ready  <= resp_last && (own == OWN_D);

         if (state == IDLE)  cancel <= 1'b0;
         else if (cancel_set) cancel <= 1'b1;

         if (gnt_d) begin
            own       <= OWN_D;
            we_q      <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
         end else if (gnt_i) begin
            own       <= OWN_I;
            we_q      <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
         end

         if (state == ISSUE)                   cnt <= CNT_W'(LAT - 1);
         else if (state == WAIT && cnt != '0)  cnt <= cnt - 1'b1;

         // A cancelled fetch leaves if_rdata untouched so it only changes with if_ready.
         if (resp_last) begin
            if (own == OWN_D)  d_rdata  <= we_q ? '0 : mem_rdata;
            else if (!drop_i)  if_rdata <= mem_rdata;
         end
      end
   end

`ifdef ARB_PERF_CNT_EN
   logic [2:0][31:0] perf_cnt;

   arb_perf_cnt #(.N(3), .W(32)) u_perf (
      .clk   (clk),
      .reset (reset),
      .inc   ({resp_last && drop_i, d_req && !d_ready, if_req && !if_ready}),
      .cnt   (perf_cnt)
   );

   assign perf_if_stall = perf_cnt[0];
   assign perf_d_stall  = perf_cnt[1];
   assign perf_flushed  = perf_cnt[2];
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench: randomized fetch/data traffic against a cycle-budget reference model.
module tb_unified_mem_arbiter;

   localparam int LAT = 2;
   localparam int DW  = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          if_req, if_flush, if_ready, d_req, d_we, d_ready, mem_en, mem_we;
   logic [DW-1:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
`ifdef ARB_PERF_CNT_EN
   logic [31:0]   perf_if_stall, perf_d_stall, perf_flushed;
`endif

   // second instance with LAT=1, fetch port only
   logic          if_req1, if_ready1, d_ready1, mem_en1, mem_we1;
   logic [DW-1:0] if_addr1, if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
   logic          zero1 = 1'b0;
   logic [DW-1:0] zero32 = '0;

   unified_mem_arbiter #(.LAT(LAT), .DW(DW)) u_dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
      .if_ready(if_ready), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ready(d_ready), .d_rdata(d_rdata),
`ifdef ARB_PERF_CNT_EN
      .perf_if_stall(perf_if_stall), .perf_d_stall(perf_d_stall), .perf_flushed(perf_flushed),
`endif
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

`ifdef ARB_PERF_CNT_EN
   logic [31:0] pf1_if, pf1_d, pf1_fl;
`endif

   unified_mem_arbiter #(.LAT(1), .DW(DW)) u_dut1 (
      .clk(clk), .reset(reset),
      .if_req(if_req1), .if_addr(if_addr1), .if_flush(zero1),
      .if_ready(if_ready1), .if_rdata(if_rdata1),
      .d_req(zero1), .d_we(zero1), .d_addr(zero32), .d_wdata(zero32),
      .d_ready(d_ready1), .d_rdata(d_rdata1),
`ifdef ARB_PERF_CNT_EN
      .perf_if_stall(pf1_if), .perf_d_stall(pf1_d), .perf_flushed(pf1_fl),
`endif
      .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
      .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'hC0DE0000;
   endfunction

   // Memory: data for the address strobed LAT cycles earlier, random junk otherwise.
   logic          vh [1:LAT];
   logic [31:0]   ah [1:LAT];
   logic [31:0]   junk;
   logic          vh1;
   logic [31:0]   ah1;
   always @(posedge clk) begin
      vh[1] <= mem_en;
      ah[1] <= mem_addr;
      for (int k = 2; k <= LAT; k++) begin
         vh[k] <= vh[k-1];
         ah[k] <= ah[k-1];
      end
      vh1  <= mem_en1;
      ah1  <= mem_addr1;
      junk <= $urandom;
   end
   assign mem_rdata  = vh[LAT] ? mem_word(ah[LAT]) : junk;
   assign mem_rdata1 = vh1 ? mem_word(ah1) : ~junk;

   int checks = 0, passed = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
   endtask

   typedef struct { int cyc; logic we; logic [31:0] addr; logic [31:0] wdata; } mem_exp_t;
   typedef struct { int cyc; logic d; logic [31:0] data; logic cancel; } rdy_exp_t;
   mem_exp_t mq[$];
   rdy_exp_t rq[$];

   // Reference model: one access occupies the memory for LAT+3 cycles from its grant.
   int free_at = 0, g_i = 0;
   logic i_out = 1'b0;
   int pis = 0, pds = 0, pfl = 0;
   always @(posedge clk) begin
      if (reset) begin
         while (mq.size() > 0 && mq[$].cyc > cyc) void'(mq.pop_back());
         while (rq.size() > 0 && rq[$].cyc > cyc) void'(rq.pop_back());
         free_at = cyc + 1;
         i_out = 1'b0;
         pis = 0; pds = 0; pfl = 0;
      end else begin
         if (if_req && !if_ready) pis++;
         if (d_req && !d_ready)   pds++;
         if (if_flush && i_out && cyc >= g_i + 1 && cyc <= g_i + 1 + LAT && rq.size() > 0) begin
            if (!rq[rq.size()-1].cancel) pfl++;
            rq[rq.size()-1].cancel = 1'b1;
         end
         if (cyc >= free_at) begin
            if (d_req) begin
               mq.push_back('{cyc + 1, d_we, d_addr, d_wdata});
               rq.push_back('{cyc + 2 + LAT, 1'b1, d_we ? 32'h0 : mem_word(d_addr), 1'b0});
               free_at = cyc + LAT + 3;
               i_out = 1'b0;
            end else if (if_req && !if_flush) begin
               mq.push_back('{cyc + 1, 1'b0, if_addr, 32'h0});
               rq.push_back('{cyc + 2 + LAT, 1'b0, mem_word(if_addr), 1'b0});
               free_at = cyc + LAT + 3;
               i_out = 1'b1;
               g_i = cyc;
            end
         end
      end
   end

   // Monitor: compares every memory strobe and ready pulse against the scoreboard.
   always @(negedge clk) begin
      mem_exp_t me;
      rdy_exp_t re;
      if (mem_en) begin
         if (mq.size() == 0) chk("unexpected mem_en", mem_en, 1'b0);
         else begin
            me = mq.pop_front();
            chk("mem_en cycle", cyc, me.cyc);
            chk("mem_we", mem_we, me.we);
            chk("mem_addr", mem_addr, me.addr);
            if (me.we) chk("mem_wdata", mem_wdata, me.wdata);
         end
      end else if (mq.size() > 0 && mq[0].cyc <= cyc) begin
         chk("missing mem_en", mem_en, 1'b1);
         void'(mq.pop_front());
      end
      while (rq.size() > 0 && rq[0].cancel && rq[0].cyc <= cyc) void'(rq.pop_front());
      if (if_ready || d_ready) begin
         if (rq.size() == 0) chk("unexpected ready", {if_ready, d_ready}, 2'b00);
         else begin
            re = rq.pop_front();
            chk("ready cycle", cyc, re.cyc);
            chk("ready port", {if_ready, d_ready}, {!re.d, re.d});
            chk("rdata", re.d ? d_rdata : if_rdata, re.data);
         end
      end else if (rq.size() > 0 && rq[0].cyc <= cyc) begin
         chk("missing ready", {if_ready, d_ready}, {!rq[0].d, rq[0].d});
         void'(rq.pop_front());
      end
   end

   logic d_done = 1'b0, i_done = 1'b0, rnd = 1'b0;

   task automatic tick();
      @(negedge clk);
      if (d_done) d_req = 1'b0;
      if (i_done) if_req = 1'b0;
      if_flush = 1'b0;
      if (rnd) begin
         if (!d_req && $urandom_range(0, 3) == 0) begin
            d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
            d_addr = $urandom & 32'hFFFC; d_wdata = $urandom;
         end
         if (if_req && !if_ready && !i_done && $urandom_range(0, 15) == 0) begin
            if_flush = 1'b1; if_addr = $urandom & 32'hFFFC;
         end else if (!if_req && $urandom_range(0, 1) == 0) begin
            if_req = 1'b1; if_addr = $urandom & 32'hFFFC;
         end
      end
      d_done = d_ready;
      i_done = if_ready;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " mem_en"}, mem_en, 0);       chk({tag, " mem_we"}, mem_we, 0);
      chk({tag, " mem_addr"}, mem_addr, 0);   chk({tag, " mem_wdata"}, mem_wdata, 0);
      chk({tag, " if_ready"}, if_ready, 0);   chk({tag, " d_ready"}, d_ready, 0);
      chk({tag, " if_rdata"}, if_rdata, 0);   chk({tag, " d_rdata"}, d_rdata, 0);
   endtask

   initial begin
      reset = 1'b1; if_req = 0; if_addr = 0; if_flush = 0;
      d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; if_req1 = 0; if_addr1 = 0;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      reset = 1'b0;

      // lone fetch
      tick(); if_req = 1'b1; if_addr = 32'h40;
      repeat (8) tick();
      // simultaneous load and fetch: data first
      tick(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; if_req = 1'b1; if_addr = 32'h80;
      repeat (14) tick();
      // store
      tick(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEADBEEF;
      repeat (8) tick();
      // fetch flushed while waiting, then a normal fetch
      tick(); if_req = 1'b1; if_addr = 32'h200;
      tick(); tick(); if_flush = 1'b1; if_req = 1'b0;
      repeat (6) tick();
      if_req = 1'b1; if_addr = 32'h300;
      repeat (8) tick();

      rnd = 1'b1;
      repeat (3000) tick();
      rnd = 1'b0;
      repeat (40) tick();

      // reset while a fetch is in WAIT
      tick(); if_req = 1'b1; if_addr = 32'h500;
      tick(); tick(); reset = 1'b1; if_req = 1'b0;
      @(negedge clk);
      chk_zero("midreset");
      reset = 1'b0; d_done = 1'b0; i_done = 1'b0;
      repeat (10) tick();

      // LAT=1: mem_en at t+1, ready at t+3
      @(negedge clk); if_req1 = 1'b1; if_addr1 = 32'h44;
      @(negedge clk);
      chk("lat1 mem_en", mem_en1, 1'b1); chk("lat1 mem_addr", mem_addr1, 32'h44);
      chk("lat1 mem_we", mem_we1, 1'b0);
      @(negedge clk); chk("lat1 early ready", if_ready1, 1'b0);
      @(negedge clk);
      chk("lat1 ready", if_ready1, 1'b1); chk("lat1 rdata", if_rdata1, mem_word(32'h44));
      chk("lat1 d_ready", d_ready1, 1'b0);
      if_req1 = 1'b0;
      @(negedge clk); chk("lat1 ready pulse", if_ready1, 1'b0);

      chk("mem queue drained", mq.size(), 0);
      chk("ready queue drained", rq.size(), 0);
`ifdef ARB_PERF_CNT_EN
      @(posedge clk); #1;
      chk("perf_if_stall", perf_if_stall, pis);
      chk("perf_d_stall", perf_d_stall, pds);
      chk("perf_flushed", perf_flushed, pfl);
`endif
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
